// File: rtl/mem2wb_pkg.sv
// Shared types and constants for the memory-to-Wishbone bridge.
package mem2wb_pkg;

    // Bridge FSM: IDLE accepts a request, BUS holds the Wishbone cycle,
    // RESP emits the single completion beat.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mem2wb_state_t;

    // Default abort threshold, in BUS cycles without ack.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Counter width covers the full 1..65535 timeout range.
    localparam int unsigned TIMEOUT_CNT_W = 16;

    // Default Wishbone widths of the peripheral subsystem.
    localparam int unsigned WB_AD_WIDTH_DEF  = 32;
    localparam int unsigned WB_DAT_WIDTH_DEF = 32;

endpackage

// File: rtl/mem2wb_if.sv
// Wishbone classic bus between the bridge (master) and a peripheral (slave).
interface mem2wb_if #(
    parameter int unsigned AD_WIDTH  = 32,
    parameter int unsigned DAT_WIDTH = 32
);
    logic                   chip_wbs_cyc;
    logic                   chip_wbs_stb;
    logic                   chip_wbs_we;
    logic [AD_WIDTH-1:0]    chip_wbs_addr;
    logic [DAT_WIDTH-1:0]   chip_wbs_wdata;
    logic [DAT_WIDTH/8-1:0] chip_wbs_sel;
    logic [DAT_WIDTH-1:0]   wbs_chip_rdata;
    logic                   wbs_chip_ack;

    modport master (
        output chip_wbs_cyc, chip_wbs_stb, chip_wbs_we,
        output chip_wbs_addr, chip_wbs_wdata, chip_wbs_sel,
        input  wbs_chip_rdata, wbs_chip_ack
    );

    modport slave (
        input  chip_wbs_cyc, chip_wbs_stb, chip_wbs_we,
        input  chip_wbs_addr, chip_wbs_wdata, chip_wbs_sel,
        output wbs_chip_rdata, wbs_chip_ack
    );
endinterface

// File: rtl/mem2wb_timeout_cnt.sv
// Saturating wait-state counter with an expiry flag for the Wishbone cycle.
// expired_o is asserted in the cycle whose increment would make the count
// reach LIMIT, so the abort takes effect after exactly LIMIT ack-less cycles.
module wb_timeout_cnt
    import mem2wb_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam logic [TIMEOUT_CNT_W-1:0] LIMIT_M1 = TIMEOUT_CNT_W'(LIMIT - 1);
    localparam logic [TIMEOUT_CNT_W-1:0] ONE      = TIMEOUT_CNT_W'(1);

    logic [TIMEOUT_CNT_W-1:0] count_q;
    logic [TIMEOUT_CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up while enabled and not saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    assign expired_o = en_i && (count_q >= LIMIT_M1);

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mem2wb.sv
// Single-beat memory request to Wishbone classic master bridge.
// Memory side handshake: a request is taken on a cycle where req_i and gnt_o
// are both high; gnt_o is high exactly when the bridge is idle. Each taken
// request yields exactly one rvalid_o pulse that cannot be back-pressured.
// AXI_DATA_WIDTH must equal WB_DAT_WIDTH.
module mem2wb
    import mem2wb_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned WB_AD_WIDTH    = WB_AD_WIDTH_DEF,
    parameter int unsigned WB_DAT_WIDTH   = WB_DAT_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic                      we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic                      rerr_o,
    output mem2wb_state_t             state_o,
    mem2wb_if.master                  wb
);
    mem2wb_state_t           state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [WB_AD_WIDTH-1:0]  addr_q, addr_d;
    logic [WB_DAT_WIDTH-1:0] wdata_q, wdata_d;
    logic [WB_DAT_WIDTH/8-1:0] sel_q, sel_d;
    logic                    rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    rerr_q, rerr_d;

    logic [WB_AD_WIDTH-1:0]  addr_ext;
    logic                    cnt_en;
    logic                    cnt_clr;
    logic                    cnt_expired;

    // Byte address truncated or zero-extended onto the Wishbone address width.
    if (WB_AD_WIDTH > AXI_ADDR_WIDTH) begin : g_addr_zext
        assign addr_ext = {{(WB_AD_WIDTH - AXI_ADDR_WIDTH){1'b0}}, addr_i};
    end else begin : g_addr_trunc
        assign addr_ext = addr_i[WB_AD_WIDTH-1:0];
    end

    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (cnt_en),
        .clr_i     (cnt_clr),
        .expired_o (cnt_expired)
    );

    // Next-state and next-output logic; bus attributes hold unless a request is taken.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_ext;
                    wdata_d = wdata_i;
                    sel_d   = we_i ? be_i : '1;
                end
            end
            ST_BUS: begin
                cnt_clr = 1'b0;
                cnt_en  = !wb.wbs_chip_ack;
                // Ack is checked first so it wins over a simultaneous expiry.
                if (wb.wbs_chip_ack) begin
                    state_d  = ST_RESP;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    rdata_d  = we_q ? '0 : wb.wbs_chip_rdata;
                    rerr_d   = 1'b0;
                    rvalid_d = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (cnt_expired) begin
                    state_d  = ST_RESP;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    rvalid_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
                rerr_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus cycle immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    assign gnt_o             = (state_q == ST_IDLE);
    assign state_o           = state_q;
    assign rvalid_o          = rvalid_q;
    assign rdata_o           = rdata_q;
    assign rerr_o            = rerr_q;
    assign wb.chip_wbs_cyc   = cyc_q;
    assign wb.chip_wbs_stb   = stb_q;
    assign wb.chip_wbs_we    = we_q;
    assign wb.chip_wbs_addr  = addr_q;
    assign wb.chip_wbs_wdata = wdata_q;
    assign wb.chip_wbs_sel   = sel_q;
endmodule

// File: tb/tb_mem2wb.sv
// Directed bench for mem2wb: vector table of single transactions plus
// hand-written sequences for back-to-back, spurious ack and mid-cycle reset.
module tb_mem2wb;
    import mem2wb_pkg::*;

    localparam int TO = 8;

    logic          clk_i;
    logic          rst_ni;
    logic          req_i;
    logic          gnt_o;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [3:0]    be_i;
    logic [31:0]   wdata_i;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          rerr_o;
    mem2wb_state_t state_o;

    mem2wb_if #(.AD_WIDTH(32), .DAT_WIDTH(32)) wb_bus ();

    mem2wb #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .WB_AD_WIDTH    (32),
        .WB_DAT_WIDTH   (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .rerr_o   (rerr_o),
        .state_o  (state_o),
        .wb       (wb_bus)
    );

    // Clock: 10 ns period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          wait_cyc;   // BUS cycles before ack; >= TO means never
        logic [31:0] ack_data;
        logic [3:0]  exp_sel;
        int          exp_hi;     // cycles with cyc high
        logic [31:0] exp_rdata;
        logic        exp_rerr;
    } vec_t;

    vec_t vecs[6];

    // One transaction; entered and left on a negedge with the DUT idle.
    task automatic run_txn(input vec_t v, input string tag);
        int hi;
        bit done;
        check({tag, "_gnt_idle"}, 32'(gnt_o), 32'd1);
        req_i   = 1'b1;
        we_i    = v.we;
        addr_i  = v.addr;
        be_i    = v.be;
        wdata_i = v.wdata;
        @(negedge clk_i);
        req_i   = 1'b0;
        we_i    = ~v.we;
        addr_i  = 32'hFFFF_FFFF;
        wdata_i = 32'h0BAD_0BAD;
        be_i    = ~v.be;
        hi   = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (wb_bus.chip_wbs_cyc) begin
                check({tag, "_stb"},   32'(wb_bus.chip_wbs_stb),   32'd1);
                check({tag, "_we"},    32'(wb_bus.chip_wbs_we),    32'(v.we));
                check({tag, "_addr"},  wb_bus.chip_wbs_addr,       v.addr);
                check({tag, "_wdata"}, wb_bus.chip_wbs_wdata,      v.wdata);
                check({tag, "_sel"},   32'(wb_bus.chip_wbs_sel),   32'(v.exp_sel));
                check({tag, "_gnt_busy"}, 32'(gnt_o), 32'd0);
                if (hi == v.wait_cyc) begin
                    wb_bus.wbs_chip_ack   = 1'b1;
                    wb_bus.wbs_chip_rdata = v.ack_data;
                end else begin
                    wb_bus.wbs_chip_ack   = 1'b0;
                    wb_bus.wbs_chip_rdata = 32'h5EED_0000 + 32'(hi);
                end
                hi++;
                @(negedge clk_i);
            end else begin
                done = 1'b1;
            end
        end
        wb_bus.wbs_chip_ack   = 1'b0;
        wb_bus.wbs_chip_rdata = 32'h0;
        check({tag, "_bus_bound"}, 32'(done), 32'd1);
        check({tag, "_cyc_cycles"}, 32'(hi), 32'(v.exp_hi));
        check({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
        check({tag, "_rdata"},  rdata_o, v.exp_rdata);
        check({tag, "_rerr"},   32'(rerr_o), 32'(v.exp_rerr));
        check({tag, "_gnt_resp"}, 32'(gnt_o), 32'd0);
        @(negedge clk_i);
        check({tag, "_rvalid_drop"}, 32'(rvalid_o), 32'd0);
        check({tag, "_state_idle"}, 32'(state_o), 32'(ST_IDLE));
    endtask

    initial begin
        int grants, wb_cycles, rvalids, rv1_cyc, g2_cyc;
        bit prev_cyc;

        vecs[0] = '{1'b0, 32'h1000_0010, 4'h0, 32'h0,          0,  32'hCAFE_F00D, 4'hF, 1, 32'hCAFE_F00D, 1'b0};
        vecs[1] = '{1'b1, 32'h2000_0004, 4'h3, 32'h1234_5678,  3,  32'hDEAD_BEEF, 4'h3, 4, 32'h0,          1'b0};
        vecs[2] = '{1'b0, 32'h3000_0000, 4'h0, 32'h0,          99, 32'h0,         4'hF, 8, 32'h0,          1'b1};
        vecs[3] = '{1'b0, 32'h4000_0008, 4'h5, 32'h0,          7,  32'hA5A5_5A5A, 4'hF, 8, 32'hA5A5_5A5A, 1'b0};
        vecs[4] = '{1'b1, 32'h5000_000C, 4'h8, 32'h8765_4321,  1,  32'hDEAD_BEEF, 4'h8, 2, 32'h0,          1'b0};
        vecs[5] = '{1'b0, 32'h6000_0014, 4'h0, 32'h0,          2,  32'h0123_4567, 4'hF, 3, 32'h0123_4567, 1'b0};

        rst_ni = 1'b0;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        wb_bus.wbs_chip_ack = 1'b0;
        wb_bus.wbs_chip_rdata = '0;
        repeat (3) @(negedge clk_i);

        // Reset values.
        check("rst_cyc",    32'(wb_bus.chip_wbs_cyc), 32'd0);
        check("rst_stb",    32'(wb_bus.chip_wbs_stb), 32'd0);
        check("rst_we",     32'(wb_bus.chip_wbs_we),  32'd0);
        check("rst_addr",   wb_bus.chip_wbs_addr,     32'd0);
        check("rst_sel",    32'(wb_bus.chip_wbs_sel), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata",  rdata_o, 32'd0);
        check("rst_rerr",   32'(rerr_o), 32'd0);
        check("rst_state",  32'(state_o), 32'(ST_IDLE));
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Spurious ack while idle.
        for (int i = 0; i < 3; i++) begin
            wb_bus.wbs_chip_ack   = 1'b1;
            wb_bus.wbs_chip_rdata = 32'hFACE_0000 + 32'(i);
            @(negedge clk_i);
            check("spur_rvalid", 32'(rvalid_o), 32'd0);
            check("spur_cyc",    32'(wb_bus.chip_wbs_cyc), 32'd0);
            check("spur_state",  32'(state_o), 32'(ST_IDLE));
        end
        wb_bus.wbs_chip_ack = 1'b0;
        @(negedge clk_i);

        // Vector table.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back with req_i held high and a zero-wait slave.
        grants = 0; wb_cycles = 0; rvalids = 0; rv1_cyc = -1; g2_cyc = -1;
        prev_cyc = 1'b0;
        we_i = 1'b0; addr_i = 32'h7000_0000; be_i = 4'h0;
        req_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (grants >= 2) req_i = 1'b0;
            if (req_i && gnt_o) begin
                grants++;
                if (grants == 2) g2_cyc = c;
            end
            if (wb_bus.chip_wbs_cyc && !prev_cyc) wb_cycles++;
            if (rvalid_o) begin
                rvalids++;
                if (rv1_cyc < 0) rv1_cyc = c;
            end
            if (state_o != ST_IDLE) check("b2b_gnt_low", 32'(gnt_o), 32'd0);
            prev_cyc = wb_bus.chip_wbs_cyc;
            wb_bus.wbs_chip_ack   = wb_bus.chip_wbs_cyc;
            wb_bus.wbs_chip_rdata = 32'h7777_0000 + 32'(c);
            @(negedge clk_i);
        end
        wb_bus.wbs_chip_ack = 1'b0;
        check("b2b_grants",    32'(grants),    32'd2);
        check("b2b_wb_cycles", 32'(wb_cycles), 32'd2);
        check("b2b_rvalids",   32'(rvalids),   32'd2);
        check("b2b_order",     32'(g2_cyc == rv1_cyc + 1), 32'd1);

        // Reset in the middle of a Wishbone cycle.
        we_i = 1'b1; addr_i = 32'h8000_0000; be_i = 4'hF; wdata_i = 32'h1;
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        check("mrst_pre_cyc", 32'(wb_bus.chip_wbs_cyc), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mrst_cyc_async", 32'(wb_bus.chip_wbs_cyc), 32'd0);
        check("mrst_stb_async", 32'(wb_bus.chip_wbs_stb), 32'd0);
        check("mrst_state",     32'(state_o), 32'(ST_IDLE));
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("mrst_no_rvalid", 32'(rvalid_o), 32'd0);
            check("mrst_idle",      32'(state_o), 32'(ST_IDLE));
        end

        // Normal operation after reset.
        run_txn(vecs[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
